// File: rtl/effect_sequencer.sv
// Display effect sequencer: cycles effect codes with a 2-cycle blanking gap and streams seven text slots on load.
// Build macro EFFECT_SEQ_AUTO_EN enables the dwell counter and timed auto-advance.
module effect_sequencer #(
  parameter int          NUM_EFFECTS  = 5,
  parameter logic [27:0] DWELL_CYCLES = 28'd250000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_next,
  input  logic        btn_freq,
  input  logic        auto_en,
  input  logic        load_req,
  input  logic [48:0] text_in,
  output logic [2:0]  enable,
  output logic [1:0]  frequency,
  output logic [3:0]  check,
  output logic [6:0]  text_index,
  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {RUN = 2'd0, BLANK = 2'd1, LOAD = 2'd2} state_e;

  localparam logic [2:0] LAST_EFFECT = 3'(NUM_EFFECTS - 1);

  state_e      state_q, state_d;
  logic        blank_cnt_q, blank_cnt_d;
  logic [2:0]  effect_q, effect_d;
  logic        pend_q, pend_d;
  logic [2:0]  slot_q, slot_d;
  logic [6:0]  text_q [7];
  logic [6:0]  text_d [7];
  logic        btn_next_q, btn_freq_q;
  logic [1:0]  freq_q;
  logic [2:0]  enable_q, enable_d;
  logic [3:0]  check_q, check_d;
  logic [6:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        next_edge, dwell_exp, dwell_clr;

  assign next_edge = btn_next & ~btn_next_q;

  // load_req/busy handshake: a load_req pulse is accepted in any cycle where busy is low and the
  // FSM is not loading; busy rises the next cycle and stays high for exactly the 7 slot writes.
  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    effect_d    = effect_q;
    pend_d      = pend_q;
    slot_d      = slot_q;
    text_d      = text_q;
    idx_d       = idx_q;
    dwell_clr   = 1'b0;
    case (state_q)
      RUN: begin
        if (load_req) begin
          pend_d = pend_q | next_edge;
        end else if (next_edge || pend_q || dwell_exp) begin
          effect_d    = (effect_q == LAST_EFFECT) ? 3'd0 : effect_q + 3'd1;
          state_d     = BLANK;
          blank_cnt_d = 1'b0;
          pend_d      = 1'b0;
          dwell_clr   = 1'b1;
        end
      end
      BLANK: begin
        if (next_edge) pend_d = 1'b1;
        if (!load_req) begin
          if (blank_cnt_q) state_d = RUN;
          else             blank_cnt_d = 1'b1;
        end
      end
      default: begin
        if (next_edge) pend_d = 1'b1;
        if (slot_q == 3'd6) begin
          state_d     = BLANK;
          blank_cnt_d = 1'b0;
        end else begin
          slot_d = slot_q + 3'd1;
          idx_d  = text_q[slot_q + 3'd1];
        end
      end
    endcase
    // Load acceptance overrides RUN/BLANK progress; the advance (if any) was kept pending above.
    if (load_req && state_q != LOAD) begin
      for (int k = 0; k < 7; k++) text_d[k] = text_in[7*k +: 7];
      state_d   = LOAD;
      slot_d    = 3'd0;
      idx_d     = text_in[6:0];
      dwell_clr = 1'b1;
    end
    enable_d = (state_d == RUN) ? effect_d : 3'b111;
    busy_d   = (state_d == LOAD);
    check_d  = (state_d == LOAD) ? {1'b0, slot_d} : 4'hF;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BLANK;
      blank_cnt_q <= 1'b0;
      effect_q    <= 3'd0;
      pend_q      <= 1'b0;
      slot_q      <= 3'd0;
      for (int k = 0; k < 7; k++) text_q[k] <= 7'd0;
      btn_next_q  <= 1'b0;
      btn_freq_q  <= 1'b0;
      freq_q      <= 2'b01;
      enable_q    <= 3'b111;
      check_q     <= 4'hF;
      idx_q       <= 7'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      effect_q    <= effect_d;
      pend_q      <= pend_d;
      slot_q      <= slot_d;
      text_q      <= text_d;
      btn_next_q  <= btn_next;
      btn_freq_q  <= btn_freq;
      if (btn_freq && !btn_freq_q) freq_q <= freq_q + 2'd1;
      enable_q    <= enable_d;
      check_q     <= check_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
    end
  end

`ifdef EFFECT_SEQ_AUTO_EN
  logic [27:0] dwell_q;

  assign dwell_exp = (state_q == RUN) && auto_en && (dwell_q == DWELL_CYCLES - 28'd1);

  always_ff @(posedge clk) begin
    if (!rst_n || dwell_clr)          dwell_q <= 28'd0;
    else if (state_q == RUN && auto_en) dwell_q <= dwell_q + 28'd1;
  end
`else
  logic unused_cfg;

  assign dwell_exp  = 1'b0;
  assign unused_cfg = ^{auto_en, dwell_clr, DWELL_CYCLES};
`endif

  assign enable      = enable_q;
  assign frequency   = freq_q;
  assign check       = check_q;
  assign text_index  = idx_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_effect_sequencer.sv
// Bench for effect_sequencer: directed scenarios, per-cycle comparison against a behavioural model,
// plus hand-computed literal expectations.
module tb_effect_sequencer;

  localparam int N = 5;
  localparam int D = 8;
`ifdef EFFECT_SEQ_AUTO_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_next = 1'b0, btn_freq = 1'b0, auto_en = 1'b0, load_req = 1'b0;
  logic [48:0] text_in = '0;
  logic [2:0]  enable;
  logic [1:0]  frequency;
  logic [3:0]  check;
  logic [6:0]  text_index;
  logic        busy;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  effect_sequencer #(.NUM_EFFECTS(N), .DWELL_CYCLES(28'(D))) dut (
    .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_freq(btn_freq), .auto_en(auto_en),
    .load_req(load_req), .text_in(text_in), .enable(enable), .frequency(frequency),
    .check(check), .text_index(text_index), .busy(busy), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural model: blank_left counts remaining blank cycles, load_slot is the slot on show (-1 = none).
  int m_effect, m_blank_left, m_load_slot, m_dwell, m_freq;
  bit m_pend, m_prev_next, m_prev_freq;
  int m_text [7];
  int e_enable, e_check, e_idx, e_busy;

  always @(posedge clk) begin : model
    bit ne, fe, expire;
    if (!rst_n) begin
      m_effect = 0; m_blank_left = 2; m_load_slot = -1; m_dwell = 0; m_freq = 1;
      m_pend = 0; m_prev_next = 0; m_prev_freq = 0;
    end else begin
      ne = btn_next && !m_prev_next;
      fe = btn_freq && !m_prev_freq;
      m_prev_next = btn_next;
      m_prev_freq = btn_freq;
      if (fe) m_freq = (m_freq + 1) % 4;
      if (m_load_slot >= 0) begin
        if (ne) m_pend = 1;
        if (m_load_slot == 6) begin m_load_slot = -1; m_blank_left = 2; end
        else m_load_slot++;
      end else if (load_req) begin
        if (ne) m_pend = 1;
        for (int k = 0; k < 7; k++) m_text[k] = int'(text_in[7*k +: 7]);
        m_load_slot = 0;
        m_dwell = 0;
      end else if (m_blank_left > 0) begin
        if (ne) m_pend = 1;
        m_blank_left--;
      end else begin
        expire = AUTO && auto_en && (m_dwell == D - 1);
        if (ne || m_pend || expire) begin
          m_effect = (m_effect + 1) % N;
          m_blank_left = 2; m_pend = 0; m_dwell = 0;
        end else if (AUTO && auto_en) begin
          m_dwell++;
        end
      end
    end
    e_busy   = (m_load_slot >= 0) ? 1 : 0;
    e_enable = (m_load_slot >= 0 || m_blank_left > 0) ? 7 : m_effect;
    e_check  = (m_load_slot >= 0) ? m_load_slot : 15;
    e_idx    = (m_load_slot >= 0) ? m_text[m_load_slot] : 0;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_enable", int'(enable), e_enable);
      chk("model_frequency", int'(frequency), m_freq);
      chk("model_check", int'(check), e_check);
      chk("model_busy", int'(busy), e_busy);
      if (e_check != 15) chk("model_text_index", int'(text_index), e_idx);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_next();
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    int exp_seq [5];
    int exp_freq [4];
    exp_seq  = '{1, 2, 3, 4, 0};
    exp_freq = '{2, 3, 0, 1};

    // Reset and idle: 111, 111, then effect 0.
    tick(); chk_en = 1'b1; tick();
    rst_n = 1'b1;
    chk("rst_enable0", int'(enable), 7);
    chk("rst_freq", int'(frequency), 1);
    chk("rst_check", int'(check), 15);
    chk("rst_busy", int'(busy), 0);
    tick(); chk("rst_enable1", int'(enable), 7);
    tick(); chk("rst_enable2", int'(enable), 0);

    // Five advances wrap through all codes.
    for (int i = 0; i < 5; i++) begin
      press_next();
      chk("advance_code", int'(enable), exp_seq[i]);
    end

    // Text load of 10..16.
    for (int k = 0; k < 7; k++) text_in[7*k +: 7] = 7'(10 + k);
    load_req = 1'b1; tick(); load_req = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("load_check", int'(check), k);
      chk("load_index", int'(text_index), 10 + k);
      chk("load_busy", int'(busy), 1);
      tick();
    end
    chk("load_done_check", int'(check), 15);
    chk("load_done_busy", int'(busy), 0);
    chk("load_blank0", int'(enable), 7);
    tick(); chk("load_blank1", int'(enable), 7);
    tick(); chk("load_resume", int'(enable), 0);

    // Frequency stepping.
    for (int i = 0; i < 4; i++) begin
      btn_freq = 1'b1; tick();
      chk("freq_step", int'(frequency), exp_freq[i]);
      btn_freq = 1'b0; tick();
    end

    // Held btn_next during a load, second load_req ignored: one advance afterwards.
    text_in = 49'h1_2345_6789_ABCD;
    load_req = 1'b1; tick(); load_req = 1'b0;
    btn_next = 1'b1; tick(); tick();
    load_req = 1'b1; tick(); load_req = 1'b0;
    chk("ignored_load_busy", int'(busy), 1);
    repeat (17) tick();
    btn_next = 1'b0;
    repeat (5) tick();
    chk("held_single_advance", int'(enable), 1);

    // btn_next and load_req together in RUN: load first, advance after.
    btn_next = 1'b1; load_req = 1'b1; tick();
    btn_next = 1'b0; load_req = 1'b0;
    chk("coincident_load_busy", int'(busy), 1);
    repeat (20) tick();
    chk("coincident_advance", int'(enable), 2);

`ifdef EFFECT_SEQ_AUTO_EN
    auto_en = 1'b1;
    repeat (7) tick(); chk("auto_before", int'(enable), 2);
    tick(); chk("auto_blank", int'(enable), 7);
    tick(); tick(); chk("auto_next", int'(enable), 3);
    repeat (4) tick();
    auto_en = 1'b0;
    repeat (10) tick(); chk("auto_hold", int'(enable), 3);
    auto_en = 1'b1;
    repeat (3) tick(); chk("auto_resume_wait", int'(enable), 3);
    tick(); chk("auto_resume_blank", int'(enable), 7);
    auto_en = 1'b0;
    repeat (4) tick();
`else
    auto_en = 1'b1;
    repeat (40) tick();
    chk("auto_ignored", int'(enable), 2);
    auto_en = 1'b0;
    tick();
`endif

    // Reset in the middle of a load aborts it.
    load_req = 1'b1; tick(); load_req = 1'b0;
    tick(); tick();
    rst_n = 1'b0; tick();
    chk("abort_check", int'(check), 15);
    chk("abort_busy", int'(busy), 0);
    chk("abort_enable", int'(enable), 7);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort_resume", int'(enable), 0);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
